wb_gpio_ctrl: RTL and testbench
===============================

Name: wb_gpio_ctrl

Overview:
- Wishbone-B4 classic slave inside user_proj that owns the 16 user GPIO pads routed through the wrapper (io[37:30], io[7:0]).
- Provides memory-mapped output data, output-enable, synchronized input sampling, per-pin edge interrupts, and a level interrupt to the user_irq bundle.
- Sits directly downstream of the wrapper's Wishbone, io_* and irq connections; user_proj instantiates it, inverts wb_rst_i and drives wb_rst_ni.

Parameters:
- NUM_IO, 16, number of GPIO pins, 1..32
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode matches wbs_adr_i[31:8] == BASE_ADDR[31:8]
- SYNC_STAGES, 2, input synchronizer depth, >=2

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- gpio_in  in  NUM_IO  pad inputs (asynchronous)
- gpio_out  out  NUM_IO  pad output data
- gpio_oeb  out  NUM_IO  pad output enable, active-low
- irq_o  out  1  level interrupt

Behaviour:
- Reset (async assert, sync release by the parent):
  - gpio_out=0, gpio_oeb=all 1 (all inputs).
  - ack=0, dat_o=0, irq_o=0.
  - Enable and status registers = 0; synchronizer flops = 0.
- Register map (offset from BASE_ADDR, bits above NUM_IO read 0):
  - 0x00 OUT: RW
  - 0x04 OEB: RW
  - 0x08 IN: RO, synchronized value
  - 0x0C RISE_EN: RW
  - 0x10 FALL_EN: RW
  - 0x14 STATUS: read; write-1-to-clear
- Handshake:
  - Request = cyc & stb & !ack.
  - ack asserts exactly 1 cycle after the request and stays high for 1 cycle only.
  - Back-to-back requests therefore complete every 2 cycles.
  - dat_o is registered, valid with ack, and 0 when ack is low.
- Writes:
  - Take effect on the ack cycle edge, honouring sel[b] per byte.
  - sel=0 acks and changes nothing.
  - Writes to IN are ignored.
- Unmapped address: offset >=0x18 within range or decode miss with cyc&stb. Acks normally, read data 0, write has no effect. The bus never hangs.
- Input path:
  - SYNC_STAGES flop chain, plus one extra "prev" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Pad-to-IN-readable latency = SYNC_STAGES cycles.
- Status:
  - status[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - A set and a W1C clear of the same bit in the same cycle: set wins.
  - Disabling an enable does not clear pending status.
- irq_o: registered OR-reduce of status, so it lags status by 1 cycle.
- Reset asserted mid-transaction: ack drops immediately. The master must restart after reset.
- No state machine beyond the 2-state ack (IDLE/ACK). IDLE→ACK on request; ACK→IDLE unconditionally.

Decomposition:
- Package wb_gpio_pkg: register offset localparams (OFS_OUT..OFS_STATUS), address-decode width constant, reg-select enum.
- Sub-module gpio_sync_edge: per-vector SYNC_STAGES synchronizer plus prev flop; outputs sync, rise, fall.

Test Plan:
- Reset check:
  - Stimulus: hold wb_rst_ni=0, drive random bus inputs.
  - Required: gpio_oeb=16'hFFFF, gpio_out=0, ack=0, irq_o=0.
  - Then release reset and read OEB → 0x0000FFFF.
- Byte-select write:
  - Stimulus: write OUT=0x0000A5C3 with sel=4'b0010.
  - Required: gpio_out=16'hA500. Read OUT → 0x0000A500.
  - Ack exactly 1 cycle after stb, 1 cycle wide.
- Input sampling:
  - Stimulus: set gpio_in=16'h1234 at cycle N.
  - Required: a read of IN issued so it samples at cycle N+1 returns the old value. A read at N+2 returns 0x00001234 (SYNC_STAGES=2).
- Rising-edge interrupt:
  - Stimulus: RISE_EN=0x0001, then pulse gpio_in[0] 0→1.
  - Required: STATUS=0x0001, irq_o rises 1 cycle after status.
  - Then write STATUS=0x0001 → status 0, irq_o drops next cycle.
  - gpio_in[1] edge with its enable clear → no status.
- Set-wins collision:
  - Stimulus: FALL_EN=0x0004; time a gpio_in[2] falling edge to land on the same cycle as a W1C write 0x0004.
  - Required: STATUS reads 0x0004 afterwards, irq_o stays 1.
- Unmapped access and mid-transaction reset:
  - Stimulus: read offset 0x40 → ack, data 0. Write 0x40=0xFFFF.
  - Required: no register changes.
  - Stimulus: assert reset while a request is pending → ack never asserts; all outputs return to reset values.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Shared constants and types for the Wishbone GPIO controller.
// Register offsets, decode width and the register-select enum.
package wb_gpio_pkg;

  localparam int OFS_W = 8;

  localparam logic [OFS_W-1:0] OFS_OUT     = 8'h00;
  localparam logic [OFS_W-1:0] OFS_OEB     = 8'h04;
  localparam logic [OFS_W-1:0] OFS_IN      = 8'h08;
  localparam logic [OFS_W-1:0] OFS_RISE_EN = 8'h0C;
  localparam logic [OFS_W-1:0] OFS_FALL_EN = 8'h10;
  localparam logic [OFS_W-1:0] OFS_STATUS  = 8'h14;

  typedef enum logic [2:0] {
    REG_OUT,
    REG_OEB,
    REG_IN,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } ack_state_e;

  // Misaligned offsets fall through to REG_NONE and behave as unmapped.
  function automatic reg_sel_e decodeReg(input logic hit, input logic [OFS_W-1:0] ofs);
    reg_sel_e selVal;
    selVal = REG_NONE;
    if (hit) begin
      case (ofs)
        OFS_OUT:     selVal = REG_OUT;
        OFS_OEB:     selVal = REG_OEB;
        OFS_IN:      selVal = REG_IN;
        OFS_RISE_EN: selVal = REG_RISE_EN;
        OFS_FALL_EN: selVal = REG_FALL_EN;
        OFS_STATUS:  selVal = REG_STATUS;
        default:     selVal = REG_NONE;
      endcase
    end
    return selVal;
  endfunction

endpackage

// File: rtl/wb_gpio_ctrl_if.sv
// Wishbone-B4 classic slave bus bundle used between the wrapper and the GPIO block.
interface wb_gpio_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Multi-stage synchronizer for asynchronous pad inputs, plus a history flop
// used to detect rising and falling edges on the synchronized value.
module gpio_sync_edge #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_chain [STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) r_chain[s] <= '0;
      r_prev <= '0;
    end else begin
      r_chain[0] <= i_async;
      for (int s = 1; s < STAGES; s++) r_chain[s] <= r_chain[s-1];
      r_prev <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// Wishbone-B4 classic GPIO slave: output data/enable registers, synchronized
// input sampling, per-pin edge status with W1C clear, and a level interrupt.
module wb_gpio_ctrl
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_IO      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_gpio_ctrl_if.slave     wbs,
  input  logic [NUM_IO-1:0] gpio_in,
  output logic [NUM_IO-1:0] gpio_out,
  output logic [NUM_IO-1:0] gpio_oeb,
  output logic              irq_o
);

  ack_state_e        r_state;
  logic [NUM_IO-1:0] r_out;
  logic [NUM_IO-1:0] r_oeb;
  logic [NUM_IO-1:0] r_riseEn;
  logic [NUM_IO-1:0] r_fallEn;
  logic [NUM_IO-1:0] r_status;
  logic              r_irq;
  logic [31:0]       r_dat;

  logic              w_hit;
  logic              w_req;
  logic              w_wr;
  reg_sel_e          w_regSel;
  logic [31:0]       w_sel32;
  logic [NUM_IO-1:0] w_bmask;
  logic [NUM_IO-1:0] w_wdat;
  logic [NUM_IO-1:0] w_sync;
  logic [NUM_IO-1:0] w_rise;
  logic [NUM_IO-1:0] w_fall;
  logic [NUM_IO-1:0] w_set;
  logic [NUM_IO-1:0] w_clr;
  logic [31:0]       w_rdata;
  logic              w_unused;

  gpio_sync_edge #(
    .WIDTH  (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_async (gpio_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_hit    = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & (r_state == ST_IDLE);
  assign w_wr     = w_req & wbs.wbs_we_i;
  assign w_regSel = decodeReg(w_hit, wbs.wbs_adr_i[OFS_W-1:0]);
  assign w_sel32  = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                     {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
  assign w_bmask  = w_sel32[NUM_IO-1:0];
  assign w_wdat   = wbs.wbs_dat_i[NUM_IO-1:0];
  assign w_unused = ^{wbs.wbs_dat_i, w_sel32};

  assign w_set = (w_rise & r_riseEn) | (w_fall & r_fallEn);
  assign w_clr = (w_wr && (w_regSel == REG_STATUS)) ? (w_wdat & w_bmask) : '0;

  function automatic logic [NUM_IO-1:0] mergeBytes(input logic [NUM_IO-1:0] oldVal,
                                                    input logic [NUM_IO-1:0] newVal,
                                                    input logic [NUM_IO-1:0] mask);
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  always_comb begin
    w_rdata = '0;
    case (w_regSel)
      REG_OUT:     w_rdata[NUM_IO-1:0] = r_out;
      REG_OEB:     w_rdata[NUM_IO-1:0] = r_oeb;
      REG_IN:      w_rdata[NUM_IO-1:0] = w_sync;
      REG_RISE_EN: w_rdata[NUM_IO-1:0] = r_riseEn;
      REG_FALL_EN: w_rdata[NUM_IO-1:0] = r_fallEn;
      REG_STATUS:  w_rdata[NUM_IO-1:0] = r_status;
      default:     w_rdata = '0;
    endcase
  end

  // Status update puts the set term last so a same-cycle edge beats a W1C clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_IDLE;
      r_out    <= '0;
      r_oeb    <= '1;
      r_riseEn <= '0;
      r_fallEn <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
      r_dat    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) r_state <= ST_ACK;
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      r_dat <= (w_req && !wbs.wbs_we_i) ? w_rdata : '0;

      if (w_wr) begin
        case (w_regSel)
          REG_OUT:     r_out    <= mergeBytes(r_out, w_wdat, w_bmask);
          REG_OEB:     r_oeb    <= mergeBytes(r_oeb, w_wdat, w_bmask);
          REG_RISE_EN: r_riseEn <= mergeBytes(r_riseEn, w_wdat, w_bmask);
          REG_FALL_EN: r_fallEn <= mergeBytes(r_fallEn, w_wdat, w_bmask);
          default: ;
        endcase
      end

      r_status <= (r_status & ~w_clr) | w_set;
      r_irq    <= |r_status;
    end
  end

  assign wbs.wbs_ack_o = (r_state == ST_ACK);
  assign wbs.wbs_dat_o = r_dat;
  assign gpio_out      = r_out;
  assign gpio_oeb      = r_oeb;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Scoreboarded bench for wb_gpio_ctrl: directed corner cases followed by
// randomized bus/pad traffic checked against a register-level model.
module tb_wb_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oeb;
  logic        irq;

  wb_gpio_ctrl_if bus();

  wb_gpio_ctrl #(
    .NUM_IO      (16),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oeb  (gpio_oeb),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    bit          isRead;
    logic [31:0] exp;
    string       name;
  } txn_t;

  txn_t sbq[$];

  logic [15:0] mOut, mOeb, mRise, mFall, mStatus, mPad;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [15:0] byteMask(input logic [3:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] oldVal, input logic [31:0] dat, input logic [3:0] sel);
    logic [15:0] m;
    m = byteMask(sel);
    return (oldVal & ~m) | (dat[15:0] & m);
  endfunction

  task automatic modelReset();
    mOut = '0; mOeb = 16'hFFFF; mRise = '0; mFall = '0; mStatus = '0;
  endtask

  task automatic modelWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (adr[31:8] != BASE[31:8]) return;
    case (adr[7:0])
      8'h00: mOut  = merge16(mOut, dat, sel);
      8'h04: mOeb  = merge16(mOeb, dat, sel);
      8'h0C: mRise = merge16(mRise, dat, sel);
      8'h10: mFall = merge16(mFall, dat, sel);
      8'h14: mStatus = mStatus & ~(dat[15:0] & byteMask(sel));
      default: ;
    endcase
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] adr);
    if (adr[31:8] != BASE[31:8]) return 32'h0;
    case (adr[7:0])
      8'h00: return {16'h0, mOut};
      8'h04: return {16'h0, mOeb};
      8'h08: return {16'h0, mPad};
      8'h0C: return {16'h0, mRise};
      8'h10: return {16'h0, mFall};
      8'h14: return {16'h0, mStatus};
      default: return 32'h0;
    endcase
  endfunction

  task automatic busIdle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
  endtask

  // One complete classic cycle; ack must appear one edge after the request and last one cycle.
  task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [31:0] expRd, input string name);
    txn_t t;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
    t.isRead = !we; t.exp = expRd; t.name = name;
    sbq.push_back(t);
    if (we) modelWrite(adr, dat, sel);
    @(negedge clk);
    checkOutput({name, "_ack_rise"}, 32'(bus.wbs_ack_o), 32'h1);
    @(negedge clk);
    checkOutput({name, "_ack_fall"}, 32'(bus.wbs_ack_o), 32'h0);
    busIdle();
  endtask

  task automatic readReg(input logic [31:0] adr, input string name);
    applyStimulus(1'b0, adr, 32'h0, 4'hF, modelRead(adr), name);
  endtask

  task automatic writeReg(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input string name);
    applyStimulus(1'b1, adr, dat, sel, 32'h0, name);
  endtask

  task automatic setPads(input logic [15:0] newVal);
    @(negedge clk);
    mStatus = mStatus | ((newVal & ~mPad & mRise) | (~newVal & mPad & mFall));
    mPad    = newVal;
    gpio_in = newVal;
    repeat (5) @(negedge clk);
  endtask

  task automatic checkPins(input string name);
    checkOutput({name, "_out"}, 32'(gpio_out), 32'(mOut));
    checkOutput({name, "_oeb"}, 32'(gpio_oeb), 32'(mOeb));
    checkOutput({name, "_irq"}, 32'(irq), 32'(|mStatus));
  endtask

  function automatic logic [31:0] randAdr();
    int k;
    k = $urandom_range(0, 10);
    case (k)
      0: return BASE + 32'h00;
      1: return BASE + 32'h04;
      2: return BASE + 32'h08;
      3: return BASE + 32'h0C;
      4: return BASE + 32'h10;
      5: return BASE + 32'h14;
      6: return BASE + 32'h18;
      7: return BASE + 32'h40;
      8: return BASE + 32'hFC;
      9: return BASE + 32'h100;
      default: return 32'h2000_0004;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every ack and polices idle read data and ack width.
  logic prevAck = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    if (bus.wbs_ack_o === 1'b1) begin
      if (sbq.size() == 0) checkOutput("unexpected_ack", 32'(bus.wbs_ack_o), 32'h0);
      else begin
        t = sbq.pop_front();
        if (t.isRead) checkOutput(t.name, bus.wbs_dat_o, t.exp);
      end
      checkOutput("ack_single_cycle", 32'(prevAck), 32'h0);
    end else begin
      checkOutput("dat_idle_zero", bus.wbs_dat_o, 32'h0);
    end
    prevAck = bus.wbs_ack_o;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation ran past time limit, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    busIdle();
    modelReset();
    mPad = '0;

    // Reset held with garbage on the bus.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wbs_cyc_i = 1'($urandom); bus.wbs_stb_i = 1'($urandom); bus.wbs_we_i = 1'($urandom);
      bus.wbs_sel_i = 4'($urandom); bus.wbs_adr_i = $urandom;     bus.wbs_dat_i = $urandom;
      checkOutput("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
      checkOutput("rst_out", 32'(gpio_out), 32'h0);
      checkOutput("rst_oeb", 32'(gpio_oeb), 32'hFFFF);
      checkOutput("rst_irq", 32'(irq), 32'h0);
    end
    @(negedge clk);
    busIdle();
    rst_n = 1'b1;
    readReg(BASE + 32'h04, "rd_oeb_after_reset");

    // Byte-select write.
    writeReg(BASE + 32'h00, 32'h0000_A5C3, 4'b0010, "wr_out_sel1");
    checkOutput("bytesel_out_pin", 32'(gpio_out), 32'hA500);
    readReg(BASE + 32'h00, "rd_out_bytesel");
    writeReg(BASE + 32'h00, 32'hFFFF_FFFF, 4'b0000, "wr_out_sel0");
    readReg(BASE + 32'h00, "rd_out_sel0");
    writeReg(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, "wr_in_ignored");
    readReg(BASE + 32'h08, "rd_in_after_write");

    // Input latency: request sampled one edge after the pads -> old, two edges -> new.
    @(negedge clk);
    gpio_in = 16'h1234;
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 4'hF, 32'h0, "rd_in_too_early");
    mPad = 16'h1234;
    setPads(16'h0000);
    @(negedge clk);
    gpio_in = 16'h1234;
    @(negedge clk);
    applyStimulus(1'b0, BASE + 32'h08, 32'h0, 4'hF, 32'h0000_1234, "rd_in_in_time");
    mPad = 16'h1234;
    repeat (3) @(negedge clk);

    // Rising-edge interrupt and W1C clear.
    writeReg(BASE + 32'h0C, 32'h0000_0001, 4'hF, "wr_rise_en");
    @(negedge clk);
    gpio_in = mPad | 16'h0001;
    mPad    = gpio_in;
    mStatus = mStatus | 16'h0001;
    repeat (3) @(negedge clk);
    checkOutput("irq_lags_status", 32'(irq), 32'h0);
    @(negedge clk);
    checkOutput("irq_rise", 32'(irq), 32'h1);
    readReg(BASE + 32'h14, "rd_status_rise");
    writeReg(BASE + 32'h14, 32'h0000_0001, 4'hF, "w1c_status");
    checkOutput("irq_after_w1c", 32'(irq), 32'h0);
    readReg(BASE + 32'h14, "rd_status_cleared");
    setPads(mPad | 16'h0002);
    readReg(BASE + 32'h14, "rd_status_disabled_edge");
    checkPins("pins_after_rise");

    // Unmapped and decode-miss accesses.
    readReg(BASE + 32'h40, "rd_unmapped");
    writeReg(BASE + 32'h40, 32'h0000_FFFF, 4'hF, "wr_unmapped");
    writeReg(32'h2000_0000, 32'h0000_FFFF, 4'hF, "wr_decode_miss");
    readReg(32'h2000_0000, "rd_decode_miss");
    readReg(BASE + 32'h00, "rd_out_after_unmapped");
    readReg(BASE + 32'h04, "rd_oeb_after_unmapped");
    checkPins("pins_after_unmapped");

    // Falling edge landing on the same edge as its W1C clear.
    writeReg(BASE + 32'h10, 32'h0000_0004, 4'hF, "wr_fall_en");
    setPads(mPad | 16'h0004);
    @(negedge clk);
    gpio_in = mPad & ~16'h0004;
    mPad    = gpio_in;
    @(negedge clk);
    writeReg(BASE + 32'h14, 32'h0000_0004, 4'hF, "w1c_collide");
    mStatus = mStatus | 16'h0004;
    readReg(BASE + 32'h14, "rd_status_set_wins");
    checkOutput("irq_set_wins", 32'(irq), 32'h1);

    // Reset arriving while a request is pending.
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE;  bus.wbs_dat_i = '0;
    #2 rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst_ack", 32'(bus.wbs_ack_o), 32'h0);
      checkPins("midrst_pins");
    end
    busIdle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    readReg(BASE + 32'h00, "rd_out_after_midrst");

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = randAdr();
      if (op <= 3) writeReg(a, $urandom, 4'($urandom), "rnd_wr");
      else if (op <= 6) readReg(a, "rnd_rd");
      else if (op == 7) setPads(16'($urandom));
      else if (op == 8) writeReg(BASE + 32'h14, $urandom, 4'($urandom), "rnd_w1c");
      else checkPins("rnd_pins");
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);
    checkPins("final_pins");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
